// File: rtl/tea_engine_iter.sv
// TEA block cipher engine: one 64-bit block per transaction, encrypt or decrypt,
// iterating ROUNDS Feistel cycles with UNROLL chained rounds per clock.
module tea_engine_iter #(
  parameter int unsigned ROUNDS = 32,
  parameter int unsigned UNROLL = 1,
  parameter logic [31:0] DELTA  = 32'h9E3779B9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_mode,
  input  logic [127:0] in_key,
  input  logic [63:0]  in_block,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  out_block,
  output logic         busy
);

  localparam int unsigned N       = ROUNDS / UNROLL;
  localparam int unsigned CNT_W   = $clog2(N + 1);
  localparam logic [31:0] SUM_DEC = 32'(DELTA * ROUNDS);

  // Reject configurations where the unrolled datapath cannot cover ROUNDS exactly
  if (ROUNDS < 1 || UNROLL < 1 || (ROUNDS % UNROLL) != 0) begin : g_bad_cfg
    $error("tea_engine_iter: ROUNDS must be >= 1 and a multiple of UNROLL");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        v0_q, v0_d;
  logic [31:0]        v1_q, v1_d;
  logic [31:0]        sum_q, sum_d;
  logic [127:0]       key_q, key_d;
  logic               mode_q, mode_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [63:0]        out_block_q, out_block_d;

  logic [31:0]        v0_n, v1_n, sum_n;
  logic               accept;
  logic               last;

  // TEA mixing function on one 32-bit half
  function automatic logic [31:0] tea_f(input logic [31:0] x, input logic [31:0] kl,
                                        input logic [31:0] kr, input logic [31:0] s);
    return ((x << 4) + kl) ^ (x + s) ^ ((x >> 5) + kr);
  endfunction

  assign accept = in_valid & in_ready;
  assign last   = (state_q == S_RUN) && (cnt_q == CNT_W'(N - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid) state_d = S_RUN;
      S_RUN:   if (last) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = in_valid ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the state register
  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      S_IDLE:  in_ready = ~rst;
      S_RUN:   busy = 1'b1;
      S_DONE: begin
        out_valid = 1'b1;
        in_ready  = ~rst & out_ready;
      end
      default: ;
    endcase
  end

  // UNROLL chained rounds on the latched block, key and mode
  always_comb begin
    v0_n  = v0_q;
    v1_n  = v1_q;
    sum_n = sum_q;
    for (int i = 0; i < int'(UNROLL); i++) begin
      if (!mode_q) begin
        sum_n = sum_n + DELTA;
        v0_n  = v0_n + tea_f(v1_n, key_q[31:0], key_q[63:32], sum_n);
        v1_n  = v1_n + tea_f(v0_n, key_q[95:64], key_q[127:96], sum_n);
      end else begin
        v1_n  = v1_n - tea_f(v0_n, key_q[95:64], key_q[127:96], sum_n);
        v0_n  = v0_n - tea_f(v1_n, key_q[31:0], key_q[63:32], sum_n);
        sum_n = sum_n - DELTA;
      end
    end
  end

  // Datapath next state: load on accept, iterate in RUN, capture result on the last round
  always_comb begin
    v0_d        = v0_q;
    v1_d        = v1_q;
    sum_d       = sum_q;
    key_d       = key_q;
    mode_d      = mode_q;
    cnt_d       = cnt_q;
    out_block_d = out_block_q;
    if (accept) begin
      v0_d   = in_block[31:0];
      v1_d   = in_block[63:32];
      key_d  = in_key;
      mode_d = in_mode;
      sum_d  = in_mode ? SUM_DEC : 32'd0;
      cnt_d  = '0;
    end else if (state_q == S_RUN) begin
      v0_d  = v0_n;
      v1_d  = v1_n;
      sum_d = sum_n;
      cnt_d = cnt_q + CNT_W'(1);
      if (last) out_block_d = {v1_n, v0_n};
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      v0_q        <= '0;
      v1_q        <= '0;
      sum_q       <= '0;
      key_q       <= '0;
      mode_q      <= 1'b0;
      cnt_q       <= '0;
      out_block_q <= '0;
    end else begin
      v0_q        <= v0_d;
      v1_q        <= v1_d;
      sum_q       <= sum_d;
      key_q       <= key_d;
      mode_q      <= mode_d;
      cnt_q       <= cnt_d;
      out_block_q <= out_block_d;
    end
  end

  assign out_block = out_block_q;

endmodule

// File: tb/tb_tea_engine_iter.sv
// Self-checking bench for tea_engine_iter against a plain TEA reference model.
module tb_tea_engine_iter;

  logic         clk, rst;
  logic         in_valid, in_ready, in_mode, out_valid, out_ready, busy;
  logic [127:0] in_key;
  logic [63:0]  in_block, out_block;

  logic         a_valid, a_mode, a_oready;
  logic [127:0] a_key;
  logic [63:0]  a_block;
  logic         r4, v4, busy4, r32, v32, busy32;
  logic [63:0]  b4, b32;

  int pass_cnt = 0;
  int total_cnt = 0;

  localparam logic [63:0] ZERO_CT = 64'h94BAA940_41EA3A0A;

  tea_engine_iter dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_key(in_key), .in_block(in_block), .out_valid(out_valid), .out_ready(out_ready),
    .out_block(out_block), .busy(busy)
  );

  tea_engine_iter #(.ROUNDS(32), .UNROLL(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(a_valid), .in_ready(r4), .in_mode(a_mode),
    .in_key(a_key), .in_block(a_block), .out_valid(v4), .out_ready(a_oready),
    .out_block(b4), .busy(busy4)
  );

  tea_engine_iter #(.ROUNDS(32), .UNROLL(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(a_valid), .in_ready(r32), .in_mode(a_mode),
    .in_key(a_key), .in_block(a_block), .out_valid(v32), .out_ready(a_oready),
    .out_block(b32), .busy(busy32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference TEA, 32 cycles, written as the textbook loop
  function automatic logic [63:0] tea_ref(input logic dec, input logic [127:0] k,
                                          input logic [63:0] b);
    logic [31:0] v0, v1, sum, k0, k1, k2, k3;
    logic [31:0] delta;
    delta = 32'h9E3779B9;
    v0 = b[31:0];   v1 = b[63:32];
    k0 = k[31:0];   k1 = k[63:32];  k2 = k[95:64];  k3 = k[127:96];
    if (!dec) begin
      sum = 32'd0;
      for (int i = 0; i < 32; i++) begin
        sum = sum + delta;
        v0 = v0 + (((v1 << 4) + k0) ^ (v1 + sum) ^ ((v1 >> 5) + k1));
        v1 = v1 + (((v0 << 4) + k2) ^ (v0 + sum) ^ ((v0 >> 5) + k3));
      end
    end else begin
      sum = 32'hC6EF3720;
      for (int i = 0; i < 32; i++) begin
        v1 = v1 - (((v0 << 4) + k2) ^ (v0 + sum) ^ ((v0 >> 5) + k3));
        v0 = v0 - (((v1 << 4) + k0) ^ (v1 + sum) ^ ((v1 >> 5) + k1));
        sum = sum - delta;
      end
    end
    return {v1, v0};
  endfunction

  function automatic logic [127:0] rand_key();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [63:0] rand_blk();
    return {$urandom(), $urandom()};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a block and complete the input handshake on the next edge
  task automatic send(input logic m, input logic [127:0] k, input logic [63:0] b);
    int w;
    w = 0;
    while (!in_ready && w < 100) begin tick(); w++; end
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL send_ready: in_ready=%b required 1", in_ready);
    else pass_cnt++;
    in_valid = 1'b1; in_mode = m; in_key = k; in_block = b;
    tick();
    in_valid = 1'b0;
  endtask

  // Cycles from the current point until out_valid, with busy-high cycles counted
  task automatic wait_done(output int lat, output int bcnt);
    lat = 0; bcnt = 0;
    while (!out_valid && lat < 200) begin
      if (busy) bcnt++;
      tick();
      lat++;
    end
    total_cnt++;
    if (out_valid !== 1'b1) $display("FAIL wait_done: out_valid=%b required 1 after %0d cycles", out_valid, lat);
    else pass_cnt++;
  endtask

  task automatic consume(output logic [63:0] r);
    r = out_block;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_mode = 1'b0; in_key = '0; in_block = '0; out_ready = 1'b0;
    a_valid = 1'b0; a_mode = 1'b0; a_key = '0; a_block = '0; a_oready = 1'b0;
    tick(); tick();
    total_cnt++;
    if (in_ready !== 1'b0 || r4 !== 1'b0 || r32 !== 1'b0)
      $display("FAIL reset_in_ready_low: in_ready=%b/%b/%b required 0", in_ready, r4, r32);
    else pass_cnt++;
    rst = 1'b0;
    #1;
    total_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_block !== 64'd0 || busy !== 1'b0)
      $display("FAIL reset_state: in_ready=%b out_valid=%b out_block=%h busy=%b required 1 0 0 0",
               in_ready, out_valid, out_block, busy);
    else pass_cnt++;
    total_cnt++;
    if (r4 !== 1'b1 || r32 !== 1'b1 || v4 !== 1'b0 || v32 !== 1'b0 || busy4 !== 1'b0 || busy32 !== 1'b0)
      $display("FAIL reset_aux: r4=%b r32=%b v4=%b v32=%b busy4=%b busy32=%b required 1 1 0 0 0 0",
               r4, r32, v4, v32, busy4, busy32);
    else pass_cnt++;
  endtask

  task automatic test_vectors();
    int lat, bc;
    logic [63:0] r;
    send(1'b0, 128'd0, 64'd0);
    wait_done(lat, bc);
    total_cnt++;
    if (lat != 32 || bc != 32) $display("FAIL enc_latency: lat=%0d busy=%0d required 32 32", lat, bc);
    else pass_cnt++;
    consume(r);
    total_cnt++;
    if (r !== ZERO_CT) $display("FAIL enc_zero: got %h required %h", r, ZERO_CT);
    else pass_cnt++;
    total_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL after_consume: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
    else pass_cnt++;
    send(1'b1, 128'd0, ZERO_CT);
    wait_done(lat, bc);
    consume(r);
    total_cnt++;
    if (r !== 64'd0 || lat != 32) $display("FAIL dec_zero: got %h lat=%0d required 0 32", r, lat);
    else pass_cnt++;
  endtask

  task automatic test_random();
    int lat, bc;
    logic [127:0] k;
    logic [63:0] b, c, p;
    for (int i = 0; i < 200; i++) begin
      k = rand_key(); b = rand_blk();
      send(1'b0, k, b);
      wait_done(lat, bc);
      consume(c);
      total_cnt++;
      if (c !== tea_ref(1'b0, k, b)) $display("FAIL rand_enc[%0d]: got %h required %h", i, c, tea_ref(1'b0, k, b));
      else pass_cnt++;
      send(1'b1, k, c);
      wait_done(lat, bc);
      consume(p);
      total_cnt++;
      if (p !== b) $display("FAIL rand_roundtrip[%0d]: got %h required %h", i, p, b);
      else pass_cnt++;
    end
  endtask

  task automatic test_backpressure();
    int lat, bc, bad;
    logic [127:0] k;
    logic [63:0] b, b2, r0, r;
    k = rand_key(); b = rand_blk(); b2 = rand_blk();
    send(1'b0, k, b);
    wait_done(lat, bc);
    r0 = out_block;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid !== 1'b1 || out_block !== r0 || in_ready !== 1'b0) bad++;
    end
    total_cnt++;
    if (bad != 0 || r0 !== tea_ref(1'b0, k, b))
      $display("FAIL bp_hold: unstable cycles=%0d result=%h required 0 %h", bad, r0, tea_ref(1'b0, k, b));
    else pass_cnt++;
    in_valid = 1'b1; in_mode = 1'b0; in_key = k; in_block = b2; out_ready = 1'b1;
    #1;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL bp_release_ready: in_ready=%b required 1", in_ready);
    else pass_cnt++;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b0 || busy !== 1'b1)
      $display("FAIL b2b_start: out_valid=%b busy=%b required 0 1", out_valid, busy);
    else pass_cnt++;
    wait_done(lat, bc);
    consume(r);
    total_cnt++;
    if (lat != 32 || r !== tea_ref(1'b0, k, b2))
      $display("FAIL b2b_result: lat=%0d got %h required 32 %h", lat, r, tea_ref(1'b0, k, b2));
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int lat, bc, seen;
    logic [127:0] k;
    logic [63:0] b, r;
    k = rand_key(); b = rand_blk();
    send(1'b0, k, b);
    repeat (15) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    total_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL rst_mid_state: in_ready=%b out_valid=%b busy=%b required 1 0 0", in_ready, out_valid, busy);
    else pass_cnt++;
    seen = 0;
    repeat (40) begin tick(); if (out_valid) seen = 1; end
    total_cnt++;
    if (seen != 0) $display("FAIL rst_mid_no_output: out_valid seen=%0d required 0", seen);
    else pass_cnt++;
    k = rand_key(); b = rand_blk();
    send(1'b1, k, b);
    wait_done(lat, bc);
    consume(r);
    total_cnt++;
    if (r !== tea_ref(1'b1, k, b)) $display("FAIL rst_mid_fresh: got %h required %h", r, tea_ref(1'b1, k, b));
    else pass_cnt++;
  endtask

  task automatic test_latched();
    int lat, bc;
    logic m;
    logic [127:0] k;
    logic [63:0] b, r;
    m = 1'($urandom_range(0, 1)); k = rand_key(); b = rand_blk();
    send(m, k, b);
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1; in_mode = ~m; in_key = rand_key(); in_block = rand_blk();
      tick();
    end
    in_valid = 1'b0;
    wait_done(lat, bc);
    consume(r);
    total_cnt++;
    if (lat + 20 != 32 || r !== tea_ref(m, k, b))
      $display("FAIL latched_inputs: lat=%0d got %h required 32 %h", lat + 20, r, tea_ref(m, k, b));
    else pass_cnt++;
  endtask

  // Run one transaction through both unrolled engines in parallel
  task automatic aux_txn(input logic m, input logic [127:0] k, input logic [63:0] b,
                         output logic [63:0] o4, output logic [63:0] o32,
                         output int l4, output int l32);
    a_valid = 1'b1; a_mode = m; a_key = k; a_block = b;
    #1;
    total_cnt++;
    if (r4 !== 1'b1 || r32 !== 1'b1) $display("FAIL aux_ready: r4=%b r32=%b required 1 1", r4, r32);
    else pass_cnt++;
    @(posedge clk); #1;
    a_valid = 1'b0;
    l4 = -1; l32 = -1; o4 = '0; o32 = '0;
    for (int c = 0; c < 40; c++) begin
      if (v4 && l4 < 0) begin l4 = c; o4 = b4; end
      if (v32 && l32 < 0) begin l32 = c; o32 = b32; end
      if (l4 >= 0 && l32 >= 0) break;
      tick();
    end
    a_oready = 1'b1;
    tick();
    a_oready = 1'b0;
  endtask

  task automatic test_unroll();
    int l4, l32;
    logic [63:0] o4, o32, c;
    logic [127:0] k;
    logic [63:0] b;
    aux_txn(1'b0, 128'd0, 64'd0, o4, o32, l4, l32);
    total_cnt++;
    if (l4 != 8 || l32 != 1) $display("FAIL unroll_latency: l4=%0d l32=%0d required 8 1", l4, l32);
    else pass_cnt++;
    total_cnt++;
    if (o4 !== ZERO_CT || o32 !== ZERO_CT)
      $display("FAIL unroll_enc_zero: u4=%h u32=%h required %h", o4, o32, ZERO_CT);
    else pass_cnt++;
    aux_txn(1'b1, 128'd0, ZERO_CT, o4, o32, l4, l32);
    total_cnt++;
    if (o4 !== 64'd0 || o32 !== 64'd0) $display("FAIL unroll_dec_zero: u4=%h u32=%h required 0", o4, o32);
    else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      k = rand_key(); b = rand_blk();
      aux_txn(1'b0, k, b, o4, o32, l4, l32);
      c = tea_ref(1'b0, k, b);
      total_cnt++;
      if (o4 !== c || o32 !== c) $display("FAIL unroll_rand_enc[%0d]: u4=%h u32=%h required %h", i, o4, o32, c);
      else pass_cnt++;
      aux_txn(1'b1, k, c, o4, o32, l4, l32);
      total_cnt++;
      if (o4 !== b || o32 !== b) $display("FAIL unroll_rand_dec[%0d]: u4=%h u32=%h required %h", i, o4, o32, b);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_random();
    test_backpressure();
    test_reset_mid();
    test_latched();
    test_unroll();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
